lighthouse_pulse_decoder: RTL and testbench
===========================================

# lighthouse_pulse_decoder

Per-photodiode front-end stage directly upstream of the darkroom sensor-signal consumer: takes one raw lighthouse envelope input (one bit of the 16-bit sensor bus), synchronises and de-glitches it, and classifies pulses as sync or sweep by width. Each valid sweep becomes one timestamped record, emitted on a valid/ready interface to the downstream aggregation/Avalon logic. One instance per sensor.

## Interface
- SENSOR_ID, 0 — 4-bit ID stamped on every record
- FILTER_LEN, 4 — cycles the synchronised input must be stable before a level is accepted (2..15)
- MIN_PULSE, 50 — widths below this are ignored (1 µs at 50 MHz)
- SWEEP_MAX, 1500 — widths in [MIN_PULSE, SWEEP_MAX) are sweeps
- SYNC_BASE, 3125 — nominal code-0 sync width, cycles
- SYNC_STEP, 521 — sync width increment per code value
- PAIR_GAP, 25000 — sync-to-sync rise gap below which a sync is the second (lighthouse B) of a pair
- FRAME_TIMEOUT, 500000 — cycles without a valid sync before `active` drops
- clk  in  1  system clock (50 MHz)
- reset_n  in  1  asynchronous active-low reset
- sensor_i  in  1  raw asynchronous photodiode envelope, high = light
- out_valid  out  1  record available
- out_ready  in  1  consumer accepts record
- out_duration  out  20  sweep centre minus active sync rise, cycles
- out_lighthouse  out  1  0 = A, 1 = B
- out_axis  out  1  axis bit of the active sync code
- out_data  out  1  data bit of the active sync code
- out_sensor  out  4  SENSOR_ID
- overflow  out  1  one-cycle pulse when a record is dropped
- active  out  1  valid sync seen within FRAME_TIMEOUT (drives LED)

## Operation
- Input: 2-flop synchroniser, then glitch filter; filtered level changes only after FILTER_LEN consecutive equal samples.
- Pulse FSM on filtered level: LOW → HIGH on rising edge (latch rise time = frame timer, clear width counter); HIGH → LOW on falling edge, classify width w (saturating 16-bit):
  - w < MIN_PULSE: ignore.
  - w < SWEEP_MAX: sweep.
  - SYNC_BASE − SYNC_STEP/2 + k·SYNC_STEP ≤ w < same + SYNC_STEP, k = 0..7: sync, code = k (bit0 axis, bit1 data, bit2 skip). Comparisons against precomputed constants; no divider.
  - Otherwise: ignore.
- Sync: lighthouse = 1 if previous valid sync rise was < PAIR_GAP cycles earlier, else 0. Reload `active` timeout. If skip = 0: arm, t0 = this rise, store lighthouse/axis/data. If skip = 1: no change to arming.
- Sweep while armed: duration = (rise − t0) + (w >> 1), 20 bits; load output register; disarm (one record per sync).
- Sweep while unarmed: ignore.
- Frame timer: free-running 20-bit counter relative to t0; saturates at 2^20−1 and disarms on saturation.
- Output register one deep. Load while full and not accepted same cycle: new record dropped, overflow pulses, held record unchanged.

## Timing
- Reset: out_valid, overflow, active, out_duration, out_lighthouse, out_axis, out_data = 0; FSM LOW, unarmed; out_sensor = SENSOR_ID constant.
- sensor_i edge → filtered edge: 2 + FILTER_LEN cycles, equal for both edges so widths/durations are unbiased.
- out_valid rises the cycle after the filtered falling edge of a sweep; holds stable until out_valid && out_ready.
- Accept and new load in same cycle: register reloads, out_valid stays 1, no overflow.
- Reset mid-pulse or mid-frame: all state cleared; next accepted pulse starts clean, unarmed.

## Structure
- Shared package `darkroom_pkg`: code bit positions, default timing constants, sweep record struct (duration, lighthouse, axis, data, sensor).
- Sub-module `sensor_glitch_filter` (synchroniser + stability counter); decoder FSM, timers and output register in top.

## Test plan
- Isolated sync w=3125 at t=0, sweep rise at t=100000, w=200 → one record: duration 100100, lighthouse 0, axis 0, data 0.
- Sync w=5209 (skip), sync w=3646 rising 20000 later, sweep rising 150000 after second sync, w=100 → duration 150050, lighthouse 1, axis 1.
- 2-cycle glitches on sensor_i and pulse w=30 → no record, FSM unchanged.
- out_ready low, two armed sweeps → first record held, overflow pulses once; out_ready high → first record accepted.
- No sync for 500000 cycles → active drops; sweep while unarmed → no record.
- reset_n low mid-sync, release, sweep → no record, all outputs 0.

Source files
------------

// File: rtl/darkroom_pkg.sv
// rtl/darkroom_pkg.sv - shared timing defaults, sync code layout and sweep record type
package darkroom_pkg;

    localparam int CODE_AXIS_BIT = 0;
    localparam int CODE_DATA_BIT = 1;
    localparam int CODE_SKIP_BIT = 2;

    localparam int DEF_FILTER_LEN    = 4;
    localparam int DEF_MIN_PULSE     = 50;
    localparam int DEF_SWEEP_MAX     = 1500;
    localparam int DEF_SYNC_BASE     = 3125;
    localparam int DEF_SYNC_STEP     = 521;
    localparam int DEF_PAIR_GAP      = 25000;
    localparam int DEF_FRAME_TIMEOUT = 500000;

    typedef enum logic {
        ST_LOW  = 1'b0,
        ST_HIGH = 1'b1
    } pulse_state_e;

    typedef struct packed {
        logic [19:0] duration;
        logic        lighthouse;
        logic        axis;
        logic        data;
        logic [3:0]  sensor;
    } sweep_rec_t;

    // Lower width bound of sync code k; code k ends where code k+1 begins.
    function automatic logic [15:0] sync_bound(input int base, input int step, input int k);
        return 16'(base - step / 2 + k * step);
    endfunction

endpackage

// File: rtl/sensor_glitch_filter.sv
// rtl/sensor_glitch_filter.sv - two-flop synchroniser followed by a stability-count de-glitcher
module sensor_glitch_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_raw,
    output logic o_level
);

    localparam logic [3:0] CNT_LAST = 4'(FILTER_LEN - 1);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_level;
    logic [3:0] r_cnt;

    // Both edge directions use the same count, so pulse widths pass through unbiased.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/lighthouse_pulse_decoder.sv
// rtl/lighthouse_pulse_decoder.sv - classifies filtered lighthouse pulses and emits timestamped sweep records
module lighthouse_pulse_decoder
    import darkroom_pkg::*;
#(
    parameter logic [3:0] SENSOR_ID     = 4'd0,
    parameter int         FILTER_LEN    = DEF_FILTER_LEN,
    parameter int         MIN_PULSE     = DEF_MIN_PULSE,
    parameter int         SWEEP_MAX     = DEF_SWEEP_MAX,
    parameter int         SYNC_BASE     = DEF_SYNC_BASE,
    parameter int         SYNC_STEP     = DEF_SYNC_STEP,
    parameter int         PAIR_GAP      = DEF_PAIR_GAP,
    parameter int         FRAME_TIMEOUT = DEF_FRAME_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sensor_i,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [19:0] out_duration,
    output logic        out_lighthouse,
    output logic        out_axis,
    output logic        out_data,
    output logic [3:0]  out_sensor,
    output logic        overflow,
    output logic        active
);

    localparam logic [15:0] MIN_W     = 16'(MIN_PULSE);
    localparam logic [15:0] SWEEP_W   = 16'(SWEEP_MAX);
    localparam logic [19:0] PAIR_W    = 20'(PAIR_GAP);
    localparam logic [19:0] TIMEOUT_W = 20'(FRAME_TIMEOUT);

    logic         w_level;
    pulse_state_e r_state;
    pulse_state_e w_state_nxt;
    logic         w_rise_evt;
    logic         w_fall_evt;
    logic         w_is_sweep;
    logic         w_is_sync;
    logic [2:0]   w_code;
    logic         w_sync_evt;
    logic         w_arm;
    logic         w_sweep_hit;
    sweep_rec_t   w_rec;

    logic [15:0]  r_width;
    logic [19:0]  r_frame;
    logic [19:0] r_rise;
    logic [19:0]  r_sync_gap;
    logic [19:0]  r_rise_gap;
    logic         r_armed;
    logic         r_lh;
    logic         r_axis;
    logic         r_data;
    logic         r_active;
    logic         r_out_valid;
    logic         r_overflow;
    sweep_rec_t   r_rec;

    sensor_glitch_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filter (
        .clk    (clk),
        .reset_n(reset_n),
        .i_raw  (sensor_i),
        .o_level(w_level)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_LOW;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rise_evt  = 1'b0;
        w_fall_evt  = 1'b0;
        case (r_state)
            ST_LOW: begin
                if (w_level) begin
                    w_state_nxt = ST_HIGH;
                    w_rise_evt  = 1'b1;
                end
            end
            ST_HIGH: begin
                if (!w_level) begin
                    w_state_nxt = ST_LOW;
                    w_fall_evt  = 1'b1;
                end
            end
            default: w_state_nxt = ST_LOW;
        endcase
    end

    always_comb begin
        w_is_sweep = (r_width >= MIN_W) && (r_width < SWEEP_W);
        w_is_sync  = 1'b0;
        w_code     = '0;
        for (int k = 0; k < 8; k++) begin
            if ((r_width >= sync_bound(SYNC_BASE, SYNC_STEP, k)) &&
                (r_width <  sync_bound(SYNC_BASE, SYNC_STEP, k + 1))) begin
                w_is_sync = 1'b1;
                w_code    = 3'(k);
            end
        end
    end

    assign w_sync_evt  = w_fall_evt && w_is_sync;
    assign w_arm       = w_sync_evt && !w_code[CODE_SKIP_BIT];
    assign w_sweep_hit = w_fall_evt && w_is_sweep && r_armed;

    always_comb begin
        w_rec            = '0;
        w_rec.duration   = r_rise + {5'd0, r_width[15:1]};
        w_rec.lighthouse = r_lh;
        w_rec.axis       = r_axis;
        w_rec.data       = r_data;
        w_rec.sensor     = SENSOR_ID;
    end

    // Width counts filtered-high cycles; rise stamps are taken in frame (t0-relative) time.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_width    <= '0;
            r_rise     <= '0;
            r_rise_gap <= '0;
        end else if (w_rise_evt) begin
            r_width    <= 16'd1;
            r_rise     <= r_frame;
            r_rise_gap <= r_sync_gap;
        end else if ((r_state == ST_HIGH) && w_level && (r_width != 16'hFFFF)) begin
            r_width <= r_width + 16'd1;
        end
    end

    // On arming the frame timer restarts at the cycles elapsed since the sync rise, making t0 zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame <= '0;
            r_armed <= 1'b0;
            r_lh    <= 1'b0;
            r_axis  <= 1'b0;
            r_data  <= 1'b0;
        end else begin
            if (w_arm) begin
                r_frame <= {4'd0, r_width} + 20'd1;
            end else if (r_frame != 20'hFFFFF) begin
                r_frame <= r_frame + 20'd1;
            end
            if (w_arm) begin
                r_armed <= 1'b1;
                r_lh    <= (r_rise_gap < PAIR_W);
                r_axis  <= w_code[CODE_AXIS_BIT];
                r_data  <= w_code[CODE_DATA_BIT];
            end else if (w_sweep_hit || (r_frame == 20'hFFFFF)) begin
                r_armed <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync_gap <= 20'hFFFFF;
            r_active   <= 1'b0;
        end else if (w_sync_evt) begin
            r_sync_gap <= {4'd0, r_width} + 20'd1;
            r_active   <= 1'b1;
        end else begin
            if (r_sync_gap != 20'hFFFFF) r_sync_gap <= r_sync_gap + 20'd1;
            if (r_sync_gap >= TIMEOUT_W) r_active <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_rec       <= '{duration: '0, lighthouse: 1'b0, axis: 1'b0, data: 1'b0, sensor: SENSOR_ID};
        end else begin
            r_overflow <= 1'b0;
            if (w_sweep_hit) begin
                if (!r_out_valid || out_ready) begin
                    r_rec       <= w_rec;
                    r_out_valid <= 1'b1;
                end else begin
                    r_overflow <= 1'b1;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid      = r_out_valid;
    assign out_duration   = r_rec.duration;
    assign out_lighthouse = r_rec.lighthouse;
    assign out_axis       = r_rec.axis;
    assign out_data       = r_rec.data;
    assign out_sensor     = r_rec.sensor;
    assign overflow       = r_overflow;
    assign active         = r_active;

endmodule

// File: tb/tb_lighthouse_pulse_decoder.sv
// tb/tb_lighthouse_pulse_decoder.sv - directed scoreboard bench for lighthouse_pulse_decoder
module tb_lighthouse_pulse_decoder;
    import darkroom_pkg::*;

    localparam logic [3:0] SID = 4'd5;
    localparam int FLEN     = 4;
    localparam int MINP     = 10;
    localparam int SMAX     = 40;
    localparam int SBASE    = 100;
    localparam int SSTEP    = 16;
    localparam int PGAP     = 400;
    localparam int FTIMEOUT = 6000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sensor_i;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_duration;
    logic        out_lighthouse;
    logic        out_axis;
    logic        out_data;
    logic [3:0]  out_sensor;
    logic        overflow;
    logic        active;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int ovf_cnt = 0;
    sweep_rec_t exp_q[$];

    lighthouse_pulse_decoder #(
        .SENSOR_ID    (SID),
        .FILTER_LEN   (FLEN),
        .MIN_PULSE    (MINP),
        .SWEEP_MAX    (SMAX),
        .SYNC_BASE    (SBASE),
        .SYNC_STEP    (SSTEP),
        .PAIR_GAP     (PGAP),
        .FRAME_TIMEOUT(FTIMEOUT)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .sensor_i      (sensor_i),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_duration  (out_duration),
        .out_lighthouse(out_lighthouse),
        .out_axis      (out_axis),
        .out_data      (out_data),
        .out_sensor    (out_sensor),
        .overflow      (overflow),
        .active        (active)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int w, output int t_rise);
        @(negedge clk);
        sensor_i = 1'b1;
        t_rise   = cyc;
        repeat (w) @(negedge clk);
        sensor_i = 1'b0;
    endtask

    task automatic expect_rec(input int dur, input logic lh, input logic ax, input logic dt);
        sweep_rec_t r;
        r.duration   = 20'(dur);
        r.lighthouse = lh;
        r.axis       = ax;
        r.data       = dt;
        r.sensor     = SID;
        exp_q.push_back(r);
    endtask

    // Scoreboard side: every handshake pops one expected record.
    initial begin
        sweep_rec_t e;
        forever begin
            @(negedge clk);
            #1;
            if (overflow === 1'b1) ovf_cnt++;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_record", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rec_duration", 32'(out_duration), 32'(e.duration));
                    check("rec_lighthouse", 32'(out_lighthouse), 32'(e.lighthouse));
                    check("rec_axis", 32'(out_axis), 32'(e.axis));
                    check("rec_data", 32'(out_data), 32'(e.data));
                    check("rec_sensor", 32'(out_sensor), 32'(e.sensor));
                end
            end
        end
    end

    initial begin
        int ts, ts2, tw, tx;
        reset_n   = 1'b0;
        sensor_i  = 1'b0;
        out_ready = 1'b1;
        idle(5);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_active", 32'(active), 0);
        check("rst_duration", 32'(out_duration), 0);
        check("rst_lh_axis_data", {29'd0, out_lighthouse, out_axis, out_data}, 0);
        check("rst_sensor", 32'(out_sensor), 32'(SID));
        reset_n = 1'b1;
        idle(20);

        // Isolated code-0 sync, then one sweep.
        pulse(100, ts);
        idle(50);
        check("t1_active", 32'(active), 1);
        idle(2850);
        pulse(20, tw);
        expect_rec(tw - ts + 10, 1'b0, 1'b0, 1'b0);
        idle(50);

        // Skip sync followed closely by an axis sync: lighthouse B.
        pulse(164, ts);
        idle(136);
        pulse(116, ts2);
        idle(1884);
        pulse(12, tw);
        expect_rec(tw - ts2 + 6, 1'b1, 1'b1, 1'b0);
        idle(50);

        // Glitches and out-of-class widths must leave the armed frame intact.
        pulse(100, ts);
        idle(200);
        pulse(2, tx);
        idle(10);
        pulse(2, tx);
        idle(10);
        pulse(6, tx);
        idle(30);
        pulse(SMAX, tx);
        idle(60);
        check("glitch_no_record", 32'(out_valid), 0);
        pulse(MINP, tw);
        expect_rec(tw - ts + MINP / 2, 1'b0, 1'b0, 1'b0);
        idle(50);

        // Back-pressure: second record dropped, first held.
        out_ready = 1'b0;
        ovf_cnt   = 0;
        pulse(100, ts);
        idle(400);
        pulse(20, tw);
        expect_rec(tw - ts + 10, 1'b0, 1'b0, 1'b0);
        idle(60);
        check("bp_valid_held", 32'(out_valid), 1);
        check("bp_duration_first", 32'(out_duration), 32'(tw - ts + 10));
        pulse(116, ts2);
        idle(700);
        pulse(20, tx);
        idle(60);
        check("bp_overflow_once", 32'(ovf_cnt), 1);
        check("bp_duration_kept", 32'(out_duration), 32'(tw - ts + 10));
        check("bp_axis_kept", 32'(out_axis), 0);
        out_ready = 1'b1;
        idle(5);
        check("bp_drained", 32'(out_valid), 0);

        // Activity timeout and unarmed sweep.
        idle(FTIMEOUT + 100);
        check("timeout_active", 32'(active), 0);
        pulse(20, tx);
        idle(60);
        check("unarmed_no_record", 32'(out_valid), 0);

        // Reset in the middle of a sync while armed.
        pulse(100, ts);
        idle(100);
        check("pre_reset_active", 32'(active), 1);
        @(negedge clk);
        sensor_i = 1'b1;
        idle(50);
        reset_n = 1'b0;
        idle(3);
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_active", 32'(active), 0);
        check("mid_rst_duration", 32'(out_duration), 0);
        check("mid_rst_sensor", 32'(out_sensor), 32'(SID));
        sensor_i = 1'b0;
        idle(3);
        reset_n = 1'b1;
        idle(20);
        pulse(20, tx);
        idle(60);
        check("post_rst_no_record", 32'(out_valid), 0);
        check("post_rst_active", 32'(active), 0);
        check("post_rst_fields", {29'd0, out_lighthouse, out_axis, out_data}, 0);

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
